shift_agc: RTL and testbench
============================

# shift_agc

Automatic gain control that drives the `shift` input of the downstream 40-to-16-bit output shifter. It watches the same wide signed accumulator samples the shifter consumes and measures their peak over fixed-length blocks. From that peak it computes the smallest right-shift that keeps the output in signed `OUT_W` bits without clipping. Shift grows fast (attack) and shrinks by one step per block (decay).

## Interface
- `IN_W`, 40, signed input sample width.
- `OUT_W`, 16, downstream signed output width.
- `SHIFT_W`, 5, width of `shift`.
- `BLOCK_W`, 10, log2 of block length; a block is 2^BLOCK_W samples.

Ports:
- `ck`  in  1  clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  sample strobe; `in` is valid when high.
- `in`  in  IN_W  signed two's-complement sample.
- `shift`  out  SHIFT_W  current right-shift for the downstream shifter.
- `update`  out  1  one-cycle pulse on the cycle `shift` takes a new value.
- `clip`  out  1  one-cycle pulse: a sample did not fit at the shift current when it arrived.

## Operation
- **Magnitude.** `mag = in[IN_W-1] ? ~in : in`, taking bits `[IN_W-2:0]`. This is a sign-redundancy measure, so -2^k and 2^k-1 measure the same.
- **Required shift.** `p` is the index of the highest set bit of a magnitude.
  - `req = max(0, p - OUT_W + 2)`.
  - A zero magnitude gives `req = 0`.
  - Clamp `req` to `min(IN_W-OUT_W, 2^SHIFT_W-1)`.
- **Peak tracker.** `peak` is the bitwise OR of all magnitudes in the current block; OR keeps the same top bit as the maximum.
- **Block counter.** Counts `en` samples, 0..2^BLOCK_W-1, and wraps.
- **Block end** (last sample of the block folded in):
  - `r = req(peak | mag_of_last)`.
  - If `r > shift`: `shift <= r`.
  - Else if `r < shift`: `shift <= shift - 1` (decay is at most 1 per block).
  - Else: no change.
  - `update` pulses only if `shift` changed.
  - `peak` clears to 0 on the same cycle.
- **Clip.** Pulses when `req(mag)` of a sample is greater than the `shift` value in force on the cycle that sample's magnitude is evaluated.
- **Reset.** `shift=0`, `update=0`, `clip=0`, `peak=0`, counter=0, pipeline valid=0.
  - A partial block is discarded.
  - `en` is ignored while `rst` is high.
- **Idle.** Cycles with `en` low do not advance the counter and do not change `peak`.

## Timing
- **Pipeline.** `en` with a sample in cycle N; magnitude registered at N+1; `peak`, `shift`, `update` and `clip` register at N+2.
- **Latency.** The last sample of a block at cycle N gives its `shift` update and `update` pulse at N+2.
- **Throughput.** `en` may be high on every cycle.
  - The first sample of the next block (en at N+1) folds into the freshly cleared `peak`; no sample is lost or double-counted across the block boundary.
- **Clip timing.** `clip` for sample N is asserted at N+2. It compares against `shift` as registered at N+1.
- **Stability.** `shift` changes only on `update` cycles, so downstream always sees a stable value between updates.

## Configuration
- **`SHIFT_AGC_FAST_ATTACK_EN` defined:**
  - Every sample whose `req(mag)` exceeds `shift` raises `shift` to that `req` at N+2, mid-block, and pulses `update`.
  - If the same sample is the last of a block, the block-end rule applies to the already-raised value; the result is the max, with one `update` pulse.
  - `clip` still pulses for that sample.
- **Macro absent:** `shift` changes only at block end; `clip` alone reports mid-block overload.

## Test plan
Bench settings: `BLOCK_W=2`, defaults otherwise.
1. Reset, then 4 samples of 32767 → at block end `shift` stays 0, no `update`, no `clip`.
2. From shift 0, samples 100, -32769, 5, 0 → `clip` pulses 2 cycles after -32769. At block end `shift=1`, `update` pulses once, at N+2 after the 4th `en`.
3. Decay: from `shift=4`, feed 3 blocks of 0 → `shift` goes 3, 2, 1, with one `update` per block.
4. Extremes: -2^39 or 2^39-1 → `req=24`, `shift=24`. Feed 0 → `shift` decays by exactly 1 per block.
5. Back-to-back `en` across 3 blocks with `rst` asserted mid-second-block → all outputs 0 the cycle after. The next block counts 4 fresh samples.
6. With `SHIFT_AGC_FAST_ATTACK_EN` defined: the 2nd sample 2^20 from `shift=0` → `shift=6` and `update` pulse at N+2, before block end. Without the macro, `shift=6` appears only at block end.

Source files
------------

// File: rtl/shift_agc.sv
// Block-peak automatic gain control for the 40-to-16-bit output shifter.
// Optional build macro: SHIFT_AGC_FAST_ATTACK_EN (raise shift on any overloading sample).
module shift_agc #(
   parameter int IN_W    = 40,
   parameter int OUT_W   = 16,
   parameter int SHIFT_W = 5,
   parameter int BLOCK_W = 10
) (
   input  logic                      ck,
   input  logic                      rst,
   input  logic                      en,
   input  logic signed [IN_W-1:0]    in,
   output logic        [SHIFT_W-1:0] shift,
   output logic                      update,
   output logic                      clip
);

   localparam int SHIFT_MAX = 2**SHIFT_W - 1;
   localparam int REQ_LIM   = (IN_W - OUT_W < SHIFT_MAX) ? IN_W - OUT_W : SHIFT_MAX;

   // Smallest right shift that fits a magnitude into signed OUT_W bits.
   function automatic logic [SHIFT_W-1:0] req_shift(input logic [IN_W-2:0] m);
      int p;
      int r;
      p = -1;
      for (int i = 0; i < IN_W-1; i++) begin
         if (m[i]) p = i;
      end
      r = p - OUT_W + 2;
      if (r < 0)       r = 0;
      if (r > REQ_LIM) r = REQ_LIM;
      return SHIFT_W'(r);
   endfunction

   logic        [BLOCK_W-1:0] cnt_q, cnt_d;
   logic        [IN_W-2:0]    mag_p0;
   logic        [IN_W-2:0]    mag_p1;
   logic                      vld_p1;
   logic                      last_p1;
   logic        [IN_W-2:0]    peak_q, peak_d;
   logic        [SHIFT_W-1:0] shift_q, shift_d;
   logic                      update_q, update_d;
   logic                      clip_q, clip_d;
   logic        [SHIFT_W-1:0] req_s, blk_s, base_s;

   // Stage p0 -> p1: magnitude and block position of the incoming sample
   assign mag_p0 = in[IN_W-1] ? ~in[IN_W-2:0] : in[IN_W-2:0];
   assign cnt_d  = cnt_q + 1'b1;

   always_ff @(posedge ck) begin
      if (rst) begin
         cnt_q   <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= en;
         last_p1 <= en & (&cnt_q);
         if (en) cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge ck) begin
      if (en) mag_p1 <= mag_p0;
   end

   // Stage p1 -> p2: clip test, peak fold and shift decision
   always_comb begin
      peak_d   = peak_q;
      shift_d  = shift_q;
      update_d = 1'b0;
      clip_d   = 1'b0;
      req_s    = '0;
      blk_s    = '0;
      base_s   = shift_q;
      if (vld_p1) begin
         req_s  = req_shift(mag_p1);
         clip_d = (req_s > shift_q);
`ifdef SHIFT_AGC_FAST_ATTACK_EN
         if (req_s > shift_q) base_s = req_s;
`else
         base_s = shift_q;
`endif
         shift_d = base_s;
         if (last_p1) begin
            // The last sample is folded directly so the cleared peak is free for the next block.
            blk_s = req_shift(peak_q | mag_p1);
            if (blk_s > base_s)      shift_d = blk_s;
            else if (blk_s < base_s) shift_d = base_s - 1'b1;
            peak_d = '0;
         end else begin
            peak_d = peak_q | mag_p1;
         end
         update_d = (shift_d != shift_q);
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         peak_q   <= '0;
         shift_q  <= '0;
         update_q <= 1'b0;
         clip_q   <= 1'b0;
      end else begin
         peak_q   <= peak_d;
         shift_q  <= shift_d;
         update_q <= update_d;
         clip_q   <= clip_d;
      end
   end

   assign shift  = shift_q;
   assign update = update_q;
   assign clip   = clip_q;

endmodule

// File: tb/tb_shift_agc.sv
// Scoreboard bench for shift_agc with 4-sample blocks; honours SHIFT_AGC_FAST_ATTACK_EN.
module tb_shift_agc;

   localparam int IN_W = 40;
   localparam int SW   = 5;
`ifdef SHIFT_AGC_FAST_ATTACK_EN
   localparam bit FA = 1'b1;
`else
   localparam bit FA = 1'b0;
`endif

   typedef struct packed {
      logic          c;
      logic          u;
      logic [SW-1:0] s;
   } exp_t;

   logic                   ck = 1'b0;
   logic                   rst = 1'b1;
   logic                   en = 1'b0;
   logic signed [IN_W-1:0] din = '0;
   logic        [SW-1:0]   shift;
   logic                   update;
   logic                   clip;

   exp_t          sbq[$];
   logic          d1 = 1'b0, d2 = 1'b0, rst_q = 1'b1;
   logic [SW-1:0] cur_shift = '0;
   int            n_cmp = 0;
   int            n_err = 0;

   shift_agc #(.IN_W(IN_W), .OUT_W(16), .SHIFT_W(SW), .BLOCK_W(2)) dut (
      .ck(ck), .rst(rst), .en(en), .in(din),
      .shift(shift), .update(update), .clip(clip)
   );

   always #5 ck = ~ck;

   // Tracks which cycles carry a sample result (two cycles after capture).
   always @(posedge ck) begin
      d1    <= en && !rst;
      d2    <= rst ? 1'b0 : d1;
      rst_q <= rst;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   exp_t e;
   always @(negedge ck) begin
      if (rst_q) cur_shift = '0;
      if (d2) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow at %0t: got result with no expectation, expected queue entry", $time);
         end else begin
            e = sbq.pop_front();
            check("clip", int'(clip), int'(e.c));
            check("update", int'(update), int'(e.u));
            check("shift", int'(shift), int'(e.s));
            cur_shift = e.s;
         end
      end else begin
         check("idle_clip", int'(clip), 0);
         check("idle_update", int'(update), 0);
         check("idle_shift", int'(shift), int'(cur_shift));
      end
   end

   task automatic send(input logic signed [IN_W-1:0] v, input logic c, input logic u,
                       input logic [SW-1:0] s);
      en  = 1'b1;
      din = v;
      sbq.push_back('{c: c, u: u, s: s});
      @(posedge ck);
      #1;
      en  = 1'b0;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) @(posedge ck);
      #1;
   endtask

   // Reset for one cycle with en held high and an extreme sample that must be ignored.
   task automatic pulse_reset();
      rst = 1'b1;
      en  = 1'b1;
      din = 40'sh7F_FFFF_FFFF;
      @(posedge ck);
      sbq.delete();
      #1;
      rst = 1'b0;
      en  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge ck);
      #1;
      rst = 1'b0;
      idle(2);

      // 1: full-scale 16-bit samples need no shift
      repeat (4) send(40'sd32767, 1'b0, 1'b0, 5'd0);
      idle(2);

      // 2: -32769 needs shift 1
      send(40'sd100,    1'b0, 1'b0, 5'd0);
      send(-40'sd32769, 1'b1, FA,   FA ? 5'd1 : 5'd0);
      send(40'sd5,      1'b0, 1'b0, FA ? 5'd1 : 5'd0);
      send(40'sd0,      1'b0, !FA,  5'd1);
      idle(2);

      // 3: raise to 4 with 2^18, then decay across three empty blocks
      send(40'sd262144, 1'b1, FA,   FA ? 5'd4 : 5'd1);
      send(40'sd0,      1'b0, 1'b0, FA ? 5'd4 : 5'd1);
      send(40'sd0,      1'b0, 1'b0, FA ? 5'd4 : 5'd1);
      send(40'sd0,      1'b0, !FA,  5'd4);
      for (int b = 0; b < 3; b++) begin
         repeat (3) send(40'sd0, 1'b0, 1'b0, 5'(4 - b));
         send(40'sd0, 1'b0, 1'b1, 5'(3 - b));
      end
      idle(2);

      // 4: extremes clamp to 24, then single-step decay
      send(40'sh80_0000_0000, 1'b1, FA,   FA ? 5'd24 : 5'd1);
      send(40'sh7F_FFFF_FFFF, !FA,  1'b0, FA ? 5'd24 : 5'd1);
      send(40'sd0,            1'b0, 1'b0, FA ? 5'd24 : 5'd1);
      send(40'sd0,            1'b0, !FA,  5'd24);
      for (int b = 0; b < 2; b++) begin
         repeat (3) send(40'sd0, 1'b0, 1'b0, 5'(24 - b));
         send(40'sd0, 1'b0, 1'b1, 5'(23 - b));
      end
      idle(2);

      // 5: back-to-back blocks with a reset in the middle of the second
      pulse_reset();
      send(40'sd0,     1'b0, 1'b0, 5'd0);
      send(40'sd65536, 1'b1, FA,   FA ? 5'd2 : 5'd0);
      send(40'sd0,     1'b0, 1'b0, FA ? 5'd2 : 5'd0);
      send(40'sd0,     1'b0, !FA,  5'd2);
      send(40'sd0,     1'b0, 1'b0, 5'd2);
      send(40'sd0,     1'b0, 1'b0, 5'd2);
      pulse_reset();
      send(40'sd0,      1'b0, 1'b0, 5'd0);
      send(40'sd0,      1'b0, 1'b0, 5'd0);
      send(40'sd0,      1'b0, 1'b0, 5'd0);
      send(40'sd131072, 1'b1, 1'b1, 5'd3);
      idle(2);

      // 6: mid-block attack with 2^20 (immediate only in the fast-attack build)
      pulse_reset();
      idle(1);
      send(40'sd0,       1'b0, 1'b0, 5'd0);
      send(40'sd1048576, 1'b1, FA,   FA ? 5'd6 : 5'd0);
      send(40'sd0,       1'b0, 1'b0, FA ? 5'd6 : 5'd0);
      send(40'sd0,       1'b0, !FA,  5'd6);
      idle(4);

      check("sb_leftover", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
